// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause field positions,
// ExcCode values (also used by the decoder) and the trap FSM encoding.
package cp0_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned REG_AW      = 5;
  localparam int unsigned EXC_W       = 4;
  localparam int unsigned EXC_FIELD_W = 5;
  localparam int unsigned NUM_HW_INT  = 6;

  localparam logic [REG_AW-1:0] CP0_STATUS = 5'd12;
  localparam logic [REG_AW-1:0] CP0_CAUSE  = 5'd13;
  localparam logic [REG_AW-1:0] CP0_EPC    = 5'd14;
  localparam logic [REG_AW-1:0] CP0_PRID   = 5'd15;

  localparam int unsigned ST_IE_BIT  = 0;
  localparam int unsigned ST_EXL_BIT = 1;
  localparam int unsigned ST_IM_LO   = 10;
  localparam int unsigned CA_EXC_LO  = 2;
  localparam int unsigned CA_IP_LO   = 10;
  localparam int unsigned CA_BD_BIT  = 31;

  localparam logic [EXC_W-1:0] EXC_NONE = 4'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 4'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 4'd5;
  localparam logic [EXC_W-1:0] EXC_SYS  = 4'd8;
  localparam logic [EXC_W-1:0] EXC_RI   = 4'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 4'd12;

  typedef struct packed {
    logic [NUM_HW_INT-1:0] im;
    logic                  exl;
    logic                  ie;
  } cp0_status_t;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_TRAP_ENTRY = 2'd1,
    ST_HANDLER    = 2'd2,
    ST_RETURN     = 2'd3
  } cp0_state_e;

endpackage

// File: rtl/cp0_int_sync.sv
// hw_int synchronizer (feeds Cause.IP directly) and pending-interrupt qualification.
module cp0_int_sync
  import cp0_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HW_INT-1:0] hw_int_i,
  input  logic [NUM_HW_INT-1:0] im_i,
  input  logic                  ie_i,
  input  logic                  exl_i,
  input  logic                  int_allow_i,
  output logic [NUM_HW_INT-1:0] ip_o,
  output logic                  int_pend_c_o
);

  logic [NUM_HW_INT-1:0] ip_q;

  always_ff @(posedge clk) begin
    if (rst) ip_q <= '0;
    else     ip_q <= hw_int_i;
  end

  assign ip_o         = ip_q;
  assign int_pend_c_o = ie_i & ~exl_i & (|(ip_q & im_i)) & int_allow_i;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 responder: Status/Cause/EPC/PRId, exception and interrupt arbitration,
// one-cycle redirect pulse. Define CP0_BD_EN to add delay-slot (Cause.BD) support.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h0001_8000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [EXC_W-1:0]      exc_code,
  input  logic [XLEN-1:0]       exc_pc,
  input  logic                  int_allow,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic [REG_AW-1:0]     rd_addr,
  output logic [XLEN-1:0]       rd_data,
  input  logic                  wr_en,
  input  logic [REG_AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  eret,
`ifdef CP0_BD_EN
  input  logic                  in_delay_slot,
`endif
  output logic                  redirect,
  output logic [XLEN-1:0]       redirect_pc,
  output logic                  exl,
  output logic [XLEN-1:0]       epc
);

  cp0_state_e               state_q, state_d;
  cp0_status_t              status_q, status_d;
  logic [EXC_FIELD_W-1:0]   exccode_q, exccode_d;
  logic [XLEN-1:0]          epc_q, epc_d;
  logic                     redirect_q, redirect_d;
  logic [XLEN-1:0]          redirect_pc_q, redirect_pc_d;
  logic [NUM_HW_INT-1:0]    ip;
  logic                     int_pend_c;
  logic                     cause_bd;
  logic [XLEN-1:0]          entry_epc;
  logic [XLEN-1:0]          status_word, cause_word;
  logic                     has_exc;

  cp0_int_sync u_int_sync (
    .clk          (clk),
    .rst          (rst),
    .hw_int_i     (hw_int),
    .im_i         (status_q.im),
    .ie_i         (status_q.ie),
    .exl_i        (status_q.exl),
    .int_allow_i  (int_allow),
    .ip_o         (ip),
    .int_pend_c_o (int_pend_c)
  );

  assign has_exc = (exc_code != EXC_NONE);

`ifdef CP0_BD_EN
  logic bd_q, bd_d;
  assign entry_epc = in_delay_slot ? (exc_pc - XLEN'(4)) : exc_pc;
  assign cause_bd  = bd_q;
`else
  assign entry_epc = exc_pc;
  assign cause_bd  = 1'b0;
`endif

  // Next-state, register updates and redirect generation
  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    exccode_d     = exccode_q;
    epc_d         = epc_q;
    redirect_pc_d = redirect_pc_q;
`ifdef CP0_BD_EN
    bd_d          = bd_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (has_exc || int_pend_c) begin
          epc_d        = entry_epc;
          exccode_d    = has_exc ? {1'b0, exc_code} : '0;
          status_d.exl = 1'b1;
          state_d      = ST_TRAP_ENTRY;
`ifdef CP0_BD_EN
          bd_d         = in_delay_slot;
`endif
        end else if (eret && status_q.exl) begin
          status_d.exl = 1'b0;
          state_d      = ST_RETURN;
        end else if (wr_en) begin
          if (wr_addr == CP0_EPC) epc_d = wr_data;
          if (wr_addr == CP0_STATUS) begin
            status_d.im  = wr_data[ST_IM_LO +: NUM_HW_INT];
            status_d.exl = wr_data[ST_EXL_BIT];
            status_d.ie  = wr_data[ST_IE_BIT];
          end
        end
      end
      ST_TRAP_ENTRY: state_d = ST_HANDLER;
      ST_HANDLER: begin
        if (has_exc) begin
          exccode_d = {1'b0, exc_code};
          state_d   = ST_TRAP_ENTRY;
        end else if (eret) begin
          status_d.exl = 1'b0;
          state_d      = ST_RETURN;
        end else if (wr_en) begin
          if (wr_addr == CP0_EPC) epc_d = wr_data;
          if (wr_addr == CP0_STATUS) begin
            status_d.im  = wr_data[ST_IM_LO +: NUM_HW_INT];
            status_d.exl = wr_data[ST_EXL_BIT];
            status_d.ie  = wr_data[ST_IE_BIT];
          end
        end
      end
      ST_RETURN: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase

    // Redirect is raised for exactly the cycle spent in TRAP_ENTRY or RETURN
    redirect_d = (state_d == ST_TRAP_ENTRY) || (state_d == ST_RETURN);
    if (state_d == ST_TRAP_ENTRY)  redirect_pc_d = EXC_VECTOR;
    else if (state_d == ST_RETURN) redirect_pc_d = epc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      status_q      <= '0;
      exccode_q     <= '0;
      epc_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
`ifdef CP0_BD_EN
      bd_q          <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      status_q      <= status_d;
      exccode_q     <= exccode_d;
      epc_q         <= epc_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
`ifdef CP0_BD_EN
      bd_q          <= bd_d;
`endif
    end
  end

  // MFC0 read path reflects current state; same-cycle writes are not bypassed
  always_comb begin
    status_word                            = '0;
    status_word[ST_IM_LO +: NUM_HW_INT]    = status_q.im;
    status_word[ST_EXL_BIT]                = status_q.exl;
    status_word[ST_IE_BIT]                 = status_q.ie;
    cause_word                             = '0;
    cause_word[CA_IP_LO +: NUM_HW_INT]     = ip;
    cause_word[CA_EXC_LO +: EXC_FIELD_W]   = exccode_q;
    cause_word[CA_BD_BIT]                  = cause_bd;
    case (rd_addr)
      CP0_STATUS: rd_data = status_word;
      CP0_CAUSE:  rd_data = cause_word;
      CP0_EPC:    rd_data = epc_q;
      CP0_PRID:   rd_data = PRID_VAL;
      default:    rd_data = '0;
    endcase
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign exl         = status_q.exl;
  assign epc         = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit (covers CP0_BD_EN when defined).
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc;
  logic        int_allow;
  logic [5:0]  hw_int;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        eret;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exl;
  logic [31:0] epc;
`ifdef CP0_BD_EN
  logic        in_delay_slot;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk         (clk),
    .rst         (rst),
    .exc_code    (exc_code),
    .exc_pc      (exc_pc),
    .int_allow   (int_allow),
    .hw_int      (hw_int),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .eret        (eret),
`ifdef CP0_BD_EN
    .in_delay_slot (in_delay_slot),
`endif
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .exl         (exl),
    .epc         (epc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    rd_addr = addr;
    #1;
    check_eq(tag, rd_data, exp);
  endtask

  initial begin
    rst = 1'b1; exc_code = '0; exc_pc = '0; int_allow = 1'b1; hw_int = '0;
    rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; eret = 1'b0;
`ifdef CP0_BD_EN
    in_delay_slot = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;

    check_eq("rst_redirect", 32'(redirect), 32'd0);
    check_eq("rst_exl", 32'(exl), 32'd0);
    check_reg("rst_status", 5'd12, 32'h0);
    check_reg("rst_cause",  5'd13, 32'h0);
    check_reg("rst_epc",    5'd14, 32'h0);
    check_reg("rst_prid",   5'd15, 32'h0001_8000);
    check_reg("unmapped",   5'd3,  32'h0);

    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check_eq("eret_run_ignored", 32'(redirect), 32'd0);

    // Ov exception from RUN
    exc_code = 4'd12; exc_pc = 32'h0000_3010;
    tick();
    exc_code = '0;
    check_eq("ov_redirect", 32'(redirect), 32'd1);
    check_eq("ov_redirect_pc", redirect_pc, 32'h0000_4180);
    check_eq("ov_epc", epc, 32'h0000_3010);
    check_eq("ov_exl", 32'(exl), 32'd1);
    check_reg("ov_cause", 5'd13, 32'h0000_0030);
    tick();
    check_eq("handler_no_redirect", 32'(redirect), 32'd0);

    eret = 1'b1;
    tick();
    eret = 1'b0;
    check_eq("eret_redirect", 32'(redirect), 32'd1);
    check_eq("eret_redirect_pc", redirect_pc, 32'h0000_3010);
    check_eq("eret_exl", 32'(exl), 32'd0);
    tick();
    check_eq("return_single_pulse", 32'(redirect), 32'd0);

    // MTC0 Status then a level interrupt on hw_int[0]
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_0401;
    check_reg("mtc0_no_bypass", 5'd12, 32'h0);
    tick();
    wr_en = 1'b0;
    check_reg("status_written", 5'd12, 32'h0000_0401);
    exc_pc = 32'h0000_2000;
    hw_int = 6'b000001;
    tick();
    check_eq("int_not_yet", 32'(redirect), 32'd0);
    tick();
    hw_int = '0;
    check_eq("int_redirect", 32'(redirect), 32'd1);
    check_eq("int_redirect_pc", redirect_pc, 32'h0000_4180);
    check_eq("int_epc", epc, 32'h0000_2000);
    check_reg("int_cause", 5'd13, 32'h0000_0400);
    tick();
    check_eq("int_handler", 32'(redirect), 32'd0);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check_eq("int_eret_pc", redirect_pc, 32'h0000_2000);
    tick();

    // RI with a competing MTC0 to EPC: the write must be lost
    exc_code = 4'd10; exc_pc = 32'h0000_5000;
    wr_en = 1'b1; wr_addr = 5'd14; wr_data = 32'hDEAD_BEEF;
    tick();
    exc_code = '0; wr_en = 1'b0;
    check_eq("ri_epc", epc, 32'h0000_5000);
    check_reg("ri_cause", 5'd13, 32'h0000_0028);
    check_eq("ri_redirect", 32'(redirect), 32'd1);
    tick();

    // Nested AdEL inside the handler keeps EPC
    exc_code = 4'd4; exc_pc = 32'h0000_6000;
    tick();
    exc_code = '0;
    check_eq("nest_redirect_pc", redirect_pc, 32'h0000_4180);
    check_eq("nest_epc", epc, 32'h0000_5000);
    check_reg("nest_cause", 5'd13, 32'h0000_0010);
    tick();
    wr_en = 1'b1; wr_addr = 5'd14; wr_data = 32'h0000_7000;
    tick();
    wr_en = 1'b0;
    check_eq("handler_mtc0_epc", epc, 32'h0000_7000);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check_eq("handler_eret_pc", redirect_pc, 32'h0000_7000);
    tick();

    // Reset in the middle of a trap
    exc_code = 4'd5;
    tick();
    exc_code = '0;
    check_eq("pre_rst_redirect", 32'(redirect), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_redirect", 32'(redirect), 32'd0);
    check_eq("midrst_epc", epc, 32'h0);
    check_eq("midrst_exl", 32'(exl), 32'd0);
    tick();
    check_eq("midrst_idle", 32'(redirect), 32'd0);

`ifdef CP0_BD_EN
    exc_code = 4'd8; exc_pc = 32'h0000_3014; in_delay_slot = 1'b1;
    tick();
    exc_code = '0; in_delay_slot = 1'b0;
    check_eq("bd_epc", epc, 32'h0000_3010);
    check_reg("bd_cause", 5'd13, 32'h8000_0020);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 responder for the multistage pipeline.
- Consumes the 4-bit ExcCode, MFC0/MTC0 and ERET requests produced by the decoder and carried down the pipe.
- Holds Status, Cause, EPC and PRId, and arbitrates exceptions and interrupts.
- Issues a one-cycle redirect pulse with a target PC that the fetch/flush logic consumes.

Parameters:
- EXC_VECTOR, 32'h0000_4180, handler entry address.
- PRID_VAL, 32'h0001_8000, read-only PRId contents.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- exc_code  in  4  exception code of the committing instruction; 4'b0000 = NO_EXC
- exc_pc  in  32  PC of the committing instruction
- int_allow  in  1  committing slot holds a real instruction (not a bubble)
- hw_int  in  6  external interrupt lines, level-sensitive
- rd_addr  in  5  MFC0 register number
- rd_data  out  32  MFC0 read data
- wr_en  in  1  MTC0 write strobe
- wr_addr  in  5  MTC0 register number
- wr_data  in  32  MTC0 data
- eret  in  1  ERET committing
- redirect  out  1  one-cycle flush/redirect pulse
- redirect_pc  out  32  target PC, valid when redirect=1
- exl  out  1  Status.EXL
- epc  out  32  current EPC

Behaviour:
- Registers:
  - Status (12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause (13): IP[15:10] (read-only), ExcCode[6:2], BD[31].
  - EPC (14).
  - PRId (15) = PRID_VAL.
- Reset: Status=0, Cause=0, EPC=0, FSM=RUN, redirect=0, redirect_pc=0, and the hw_int sync flop = 0.
- Read path:
  - rd_data is combinational from the current register state.
  - Unmapped address reads 0.
  - Same-cycle write is not bypassed; the old value is returned.
- Interrupt sampling:
  - hw_int passes through one sync flop, then into Cause.IP every cycle.
  - int_pend = Status.IE & ~Status.EXL & |(IP & IM) & int_allow.
- FSM states: RUN, TRAP_ENTRY, HANDLER, RETURN.
- RUN:
  - If exc_code != 0: EPC <= exc_pc; Cause.ExcCode <= {1'b0, exc_code}; EXL <= 1; go to TRAP_ENTRY.
  - Else if int_pend: same, but ExcCode <= 0.
  - Else: MTC0 writes apply (EPC full 32 bits, Status IM/EXL/IE, Cause no writable bits in this revision).
  - ERET in RUN with EXL=0: ignored.
- TRAP_ENTRY:
  - redirect=1, redirect_pc=EXC_VECTOR.
  - Exception, interrupt, ERET and MTC0 inputs are all ignored (pipe flushing).
  - Next state: HANDLER.
- HANDLER:
  - MTC0 applies; interrupts are masked by EXL.
  - A synchronous exception (exc_code != 0): Cause.ExcCode updated, EPC unchanged, go to TRAP_ENTRY.
  - Else if eret: EXL <= 0, go to RETURN.
- RETURN:
  - redirect=1, redirect_pc=EPC; all inputs ignored.
  - Next state: RUN.
- Priority within a cycle (highest first): exception > interrupt > eret > MTC0. A losing MTC0 is discarded entirely.
- Latency: a qualifying event at edge N gives redirect high for exactly the cycle after edge N, and never two consecutive cycles.
- A reset mid-trap returns the FSM to RUN and drops any pending redirect.

Optional Feature:
- Macro: CP0_BD_EN.
- With the macro defined:
  - Extra input port in_delay_slot (1 bit).
  - On exception or interrupt entry from RUN: Cause.BD <= in_delay_slot; EPC <= in_delay_slot ? exc_pc-4 : exc_pc.
- Without it:
  - No in_delay_slot port.
  - Cause.BD is constant 0 and EPC = exc_pc.

Decomposition:
- Shared package:
  - CP0 register numbers (12/13/14/15).
  - Status and Cause bit positions.
  - The ExcCode constants (NO_EXC=0, AdEL=4, AdES=5, Sys=8, RI=10, Ov=12), shared with the decoder.
  - FSM state encoding.
- Sub-module: cp0_int_sync, covering the hw_int synchronizer plus the int_pend qualification.

Test Plan:
- Reset, then read 12/13/14/15 → 0, 0, 0, 32'h0001_8000; redirect=0.
- exc_code=12, exc_pc=32'h0000_3010 → next cycle redirect=1 with redirect_pc=32'h0000_4180; EPC=32'h0000_3010, Cause=32'h0000_0030, exl=1.
- In HANDLER, eret=1 → one cycle later redirect=1, redirect_pc=32'h0000_3010, exl=0, FSM in RUN.
- MTC0 Status=32'h0000_0401, hw_int[0]=1, int_allow=1 → exactly 2 cycles after hw_int rises, redirect=1; Cause.ExcCode=0, IP[10]=1.
- Same cycle: exc_code=10 with wr_en to EPC=32'hDEAD_BEEF → EPC=exc_pc and the MTC0 is lost.
- With CP0_BD_EN: in_delay_slot=1, exc_pc=32'h0000_3014, exc_code=8 → EPC=32'h0000_3010, Cause[31]=1.
